// File: rtl/sensor_alarm_ctrl.sv
// sensor_alarm_ctrl: N-channel sensor-to-buzzer alarm controller.
// Each channel debounces its sensor input, latches an alarm and drives a
// square-wave beep until the operator acknowledges it. The block also reports
// a summary alarm, the lowest-index alarming channel and a saturating count
// of alarms raised since reset.
// Optional build macro: BUZZER_PRIORITY_EN -- when defined, only the channel
// reported on active_ch drives its buzzer; the other channels keep running
// silently underneath.
module sensor_alarm_ctrl #(
  parameter int NUM_CH    = 3,
  parameter int DEBOUNCE  = 4,
  parameter int BEEP_HALF = 8,
  parameter int CNT_W     = 8,
  localparam int AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sensor,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] buzzer,
  output logic              any_alarm,
  output logic [AW-1:0]     active_ch,
  output logic [7:0]        alarm_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ALARM  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_HALF - 1);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  dcnt_q  [NUM_CH];
  logic [CNT_W-1:0]  dcnt_d  [NUM_CH];
  logic [CNT_W-1:0]  phase_q [NUM_CH];
  logic [CNT_W-1:0]  phase_d [NUM_CH];
  logic [NUM_CH-1:0] buzz_q;
  logic [NUM_CH-1:0] buzz_d;
  logic [NUM_CH-1:0] entry;
  logic [NUM_CH-1:0] in_alarm;
  logic [7:0]        alarm_cnt_q;
  logic [7:0]        alarm_cnt_d;

  // Number of channels entering ALARM on this edge (NUM_CH <= 16 fits 5 bits).
  function automatic logic [4:0] popcount(input logic [NUM_CH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Add k to the alarm counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] k);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, k};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Per-channel next state: debounce, latch, beep pattern and acknowledge.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      phase_d[i] = phase_q[i];
      buzz_d[i]  = buzz_q[i];
      entry[i]   = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (sensor[i]) begin
            if (DEBOUNCE == 1) begin
              state_d[i] = ST_ALARM;
              dcnt_d[i]  = '0;
              phase_d[i] = '0;
              buzz_d[i]  = 1'b1;
              entry[i]   = 1'b1;
            end else begin
              state_d[i] = ST_ARMING;
              dcnt_d[i]  = CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          // ack is deliberately ignored until the alarm is latched
          if (!sensor[i]) begin
            state_d[i] = ST_IDLE;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_ALARM;
            dcnt_d[i]  = '0;
            phase_d[i] = '0;
            buzz_d[i]  = 1'b1;
            entry[i]   = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
          end
        end
        ST_ALARM: begin
          // latched: a sensor drop alone does nothing, only ack leaves
          if (ack[i]) begin
            state_d[i] = sensor[i] ? ST_HOLD : ST_IDLE;
            phase_d[i] = '0;
            buzz_d[i]  = 1'b0;
          end else if (phase_q[i] == BEEP_LAST) begin
            phase_d[i] = '0;
            buzz_d[i]  = ~buzz_q[i];
          end else begin
            phase_d[i] = phase_q[i] + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // silenced until the sensor clears
          if (!sensor[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          dcnt_d[i]  = '0;
          phase_d[i] = '0;
          buzz_d[i]  = 1'b0;
        end
      endcase
    end
  end

  // Alarm counter advances by the number of simultaneous entries, saturating.
  always_comb begin
    alarm_cnt_d = sat_add8(alarm_cnt_q, popcount(entry));
  end

  // Summary alarm and lowest-index-wins priority encoder over registered states.
  always_comb begin
    in_alarm  = '0;
    active_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_alarm[i] = (state_q[i] == ST_ALARM);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_alarm[i]) begin
        active_ch = AW'(i);
      end
    end
    any_alarm = |in_alarm;
  end

  // Buzzer drive: every alarming channel, or only the reported one when masked.
  always_comb begin
    buzzer = '0;
`ifdef BUZZER_PRIORITY_EN
    for (int i = 0; i < NUM_CH; i++) begin
      buzzer[i] = buzz_q[i] && any_alarm && (active_ch == AW'(i));
    end
`else
    buzzer = buzz_q;
`endif
  end

  // State registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        dcnt_q[i]  <= '0;
        phase_q[i] <= '0;
      end
      buzz_q      <= '0;
      alarm_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        phase_q[i] <= phase_d[i];
      end
      buzz_q      <= buzz_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm_cnt = alarm_cnt_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Testbench for sensor_alarm_ctrl with default parameters (3 channels,
// DEBOUNCE=4, BEEP_HALF=8). Table rows hold inputs, a repeat count and the
// outputs expected after each edge; a loop at the end drives the alarm
// counter into saturation.
module tb_sensor_alarm_ctrl;

`ifdef BUZZER_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // Expected buzzer value when ch1+ch2 / all channels buzz together.
  localparam logic [2:0] BZ12  = PRIO ? 3'b010 : 3'b110;
  localparam logic [2:0] BZALL = PRIO ? 3'b001 : 3'b111;

  logic       clk;
  logic       reset;
  logic [2:0] sensor;
  logic [2:0] ack;
  logic [2:0] buzzer;
  logic       any_alarm;
  logic [1:0] active_ch;
  logic [7:0] alarm_cnt;

  typedef struct {
    logic [2:0] buz;
    logic       any;
    logic [1:0] act;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int         rep;
    logic       rst_n;
    logic [2:0] s;
    logic [2:0] a;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  sensor_alarm_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sensor    (sensor),
    .ack       (ack),
    .buzzer    (buzzer),
    .any_alarm (any_alarm),
    .active_ch (active_ch),
    .alarm_cnt (alarm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] b, input logic y,
                              input logic [1:0] c, input logic [7:0] n);
    exp_t e;
    e.buz = b;
    e.any = y;
    e.act = c;
    e.cnt = n;
    return e;
  endfunction

  task automatic add(input int rep, input logic r, input logic [2:0] s,
                     input logic [2:0] a, input exp_t e);
    vec_t v;
    v.rep   = rep;
    v.rst_n = r;
    v.s     = s;
    v.a     = a;
    v.e     = e;
    tbl.push_back(v);
  endtask

  // Drive one cycle, queue its expectation, then check it just after the edge.
  task automatic step(input logic r, input logic [2:0] s, input logic [2:0] a,
                      input exp_t e, input int id);
    exp_t x;
    reset  = r;
    sensor = s;
    ack    = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_cmp++;
    if (buzzer !== x.buz) begin
      n_bad++;
      $display("FAIL buzzer step %0d: got %b want %b", id, buzzer, x.buz);
    end
    n_cmp++;
    if (any_alarm !== x.any) begin
      n_bad++;
      $display("FAIL any_alarm step %0d: got %b want %b", id, any_alarm, x.any);
    end
    n_cmp++;
    if (active_ch !== x.act) begin
      n_bad++;
      $display("FAIL active_ch step %0d: got %0d want %0d", id, active_ch, x.act);
    end
    n_cmp++;
    if (alarm_cnt !== x.cnt) begin
      n_bad++;
      $display("FAIL alarm_cnt step %0d: got %0d want %0d", id, alarm_cnt, x.cnt);
    end
  endtask

  initial begin
    int   id;
    logic [7:0] ecnt;
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    sensor = '0;
    ack    = '0;

    // reset and idle
    add(2,  1'b0, 3'b000, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd0));
    add(20, 1'b1, 3'b000, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd0));
    // ch0 alarm on the 4th edge, 8 high / 8 low / 8 high, then ack with sensor low
    add(3,  1'b1, 3'b001, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd0));
    add(8,  1'b1, 3'b001, 3'b000, mk(3'b001, 1'b1, 2'd0, 8'd1));
    add(8,  1'b1, 3'b001, 3'b000, mk(3'b000, 1'b1, 2'd0, 8'd1));
    add(8,  1'b1, 3'b000, 3'b000, mk(3'b001, 1'b1, 2'd0, 8'd1));
    add(1,  1'b1, 3'b000, 3'b001, mk(3'b000, 1'b0, 2'd0, 8'd1));
    // glitch on ch1 never reaches ALARM
    add(3,  1'b1, 3'b010, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd1));
    add(1,  1'b1, 3'b000, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd1));
    add(3,  1'b1, 3'b010, 3'b010, mk(3'b000, 1'b0, 2'd0, 8'd1));
    add(1,  1'b1, 3'b000, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd1));
    // ch2 alarm, ack with sensor high -> HOLD, sensor low -> IDLE, re-raise
    add(3,  1'b1, 3'b100, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd1));
    add(3,  1'b1, 3'b100, 3'b000, mk(3'b100, 1'b1, 2'd2, 8'd2));
    add(2,  1'b1, 3'b100, 3'b100, mk(3'b000, 1'b0, 2'd0, 8'd2));
    add(2,  1'b1, 3'b100, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd2));
    add(1,  1'b1, 3'b000, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd2));
    add(3,  1'b1, 3'b100, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd2));
    add(1,  1'b1, 3'b100, 3'b000, mk(3'b100, 1'b1, 2'd2, 8'd3));
    // sensor drop and ack together while in ALARM -> IDLE
    add(1,  1'b1, 3'b000, 3'b100, mk(3'b000, 1'b0, 2'd0, 8'd3));
    // ch1 and ch2 together, then ack ch1 -> ch2 reported mid-pattern
    add(3,  1'b1, 3'b110, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd3));
    add(8,  1'b1, 3'b110, 3'b000, mk(BZ12,   1'b1, 2'd1, 8'd5));
    add(3,  1'b1, 3'b110, 3'b000, mk(3'b000, 1'b1, 2'd1, 8'd5));
    add(1,  1'b1, 3'b110, 3'b010, mk(3'b000, 1'b1, 2'd2, 8'd5));
    add(4,  1'b1, 3'b110, 3'b000, mk(3'b000, 1'b1, 2'd2, 8'd5));
    add(8,  1'b1, 3'b110, 3'b000, mk(3'b100, 1'b1, 2'd2, 8'd5));
    // reset with ch1 in HOLD and ch2 in ALARM, sensors held high
    add(1,  1'b0, 3'b110, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd0));
    add(3,  1'b1, 3'b110, 3'b000, mk(3'b000, 1'b0, 2'd0, 8'd0));
    add(1,  1'b1, 3'b110, 3'b000, mk(BZ12,   1'b1, 2'd1, 8'd2));
    add(1,  1'b1, 3'b000, 3'b111, mk(3'b000, 1'b0, 2'd0, 8'd2));

    id = 0;
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        step(tbl[r].rst_n, tbl[r].s, tbl[r].a, tbl[r].e, id);
        id++;
      end
    end

    // saturation: three simultaneous alarms per round until the count pins at 255
    ecnt = 8'd2;
    for (int rnd = 0; rnd < 90; rnd++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, 3'b111, 3'b000, mk(3'b000, 1'b0, 2'd0, ecnt), id);
        id++;
      end
      ecnt = (ecnt > 8'd252) ? 8'd255 : ecnt + 8'd3;
      step(1'b1, 3'b111, 3'b000, mk(BZALL, 1'b1, 2'd0, ecnt), id);
      id++;
      step(1'b1, 3'b000, 3'b111, mk(3'b000, 1'b0, 2'd0, ecnt), id);
      id++;
    end
    n_cmp++;
    if (alarm_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL saturation: got %0d want 255", alarm_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_alarm_ctrl.md
Name: sensor_alarm_ctrl

Overview:
Parametrised N-channel sensor-to-buzzer alarm controller, the successor to the fixed three-sensor state machine. Each channel debounces its sensor and latches an alarm. While the alarm is latched, the channel drives a square-wave buzzer pattern until an operator acknowledge clears it. The block sits between the raw sensor inputs and the buzzer drivers, and reports a summary alarm plus the highest-priority active channel.

Parameters:
NUM_CH, 3, number of sensor/buzzer channels (1..16)
DEBOUNCE, 4, consecutive high samples needed to raise an alarm (1..255)
BEEP_HALF, 8, buzzer half-period in clk cycles (1..255)
CNT_W, 8, width of the per-channel debounce and phase counters; must hold DEBOUNCE and BEEP_HALF

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous, active-low reset
sensor  input  NUM_CH  raw sensor level per channel, sampled directly on clk (already synchronous)
ack  input  NUM_CH  per-channel acknowledge; level sampled on clk
buzzer  output  NUM_CH  per-channel buzzer drive
any_alarm  output  1  OR of all channels in ALARM
active_ch  output  $clog2(NUM_CH) (min 1)  lowest index currently in ALARM; 0 when none
alarm_cnt  output  8  saturating count of alarms raised since reset

Behaviour:
- Reset: synchronous, active-low. Sampled low on a clk edge, it sets:
  - every channel to IDLE, with counters 0
  - buzzer=0, any_alarm=0, active_ch=0, alarm_cnt=0
  - This applies mid-operation too; nothing is held across reset.
- Per-channel FSM, all transitions evaluated on the clk edge:
  - IDLE: sensor=1 -> ARMING with dcnt=1. If DEBOUNCE==1, go straight to ALARM instead. sensor=0 -> stay.
  - ARMING, sensor=0 -> IDLE, dcnt=0.
  - ARMING, sensor=1 and dcnt==DEBOUNCE-1 -> ALARM.
  - ARMING, sensor=1 otherwise -> dcnt+1.
  - ARMING ignores ack.
  - ALARM: the alarm is latched and a sensor drop has no effect. ack=1 with sensor=0 -> IDLE. ack=1 with sensor=1 -> HOLD.
  - HOLD: silenced, buzzer 0. sensor=0 -> IDLE. ack ignored.
- ALARM entry:
  - Occurs on the edge of the DEBOUNCE-th consecutive high sample.
  - buzz_q=1 and phase=0 are registered on that same edge.
  - alarm_cnt increments once per entry and saturates at 255.
  - Simultaneous entries on k channels add k, still saturating.
- Beep pattern while in ALARM:
  - phase counts 0..BEEP_HALF-1.
  - When phase==BEEP_HALF-1: buzz_q toggles and phase wraps to 0.
  - Result: BEEP_HALF cycles high, BEEP_HALF cycles low, repeating.
  - Leaving ALARM clears buzz_q and phase on the same edge.
- Outputs:
  - buzzer[i]=buzz_q[i], registered.
  - any_alarm and active_ch are combinational from the registered states.
  - active_ch uses a lowest-index-wins priority encoder.
- Simultaneous events:
  - Channels are fully independent.
  - ack on a channel that is in IDLE or ARMING is a no-op.
  - A sensor drop and ack in the same cycle while in ALARM -> IDLE.

Optional Feature:
Macro BUZZER_PRIORITY_EN.
- Defined:
  - buzzer[i] = buzz_q[i] only when i==active_ch and any_alarm=1; every other buzzer output is forced 0.
  - Masked channels keep their FSM and phase running, so a channel that is unmasked later is in mid-pattern.
- Undefined: every channel in ALARM drives its own buzzer independently.
- FSM, alarm_cnt, any_alarm and active_ch are identical in both builds.

Test Plan:
All cases use defaults NUM_CH=3, DEBOUNCE=4, BEEP_HALF=8.

1. reset=0 for 2 edges, then 1; all sensors 0 -> buzzer=3'b000, any_alarm=0, alarm_cnt=0 for 20 cycles.
2. sensor[0]=1 held -> ALARM on the 4th sampling edge; buzzer[0]=1 for 8 cycles, 0 for 8 cycles, repeating; alarm_cnt=1, active_ch=0.
3. Glitch: sensor[1]=1 for 3 edges, 0 for 1 edge, then 1 for 3 edges -> buzzer[1] never asserts; alarm_cnt unchanged.
4. After ALARM on ch2:
   - ack[2]=1 with sensor[2]=1 -> HOLD, buzzer[2]=0 on the next cycle.
   - sensor[2]=0 -> IDLE.
   - re-raise sensor[2] -> ALARM again, alarm_cnt increments.
5. sensor[1] and sensor[2] raised on the same edge -> both ALARM on the same edge, alarm_cnt += 2, active_ch=1.
   - Without BUZZER_PRIORITY_EN: both buzzers toggle in phase.
   - With BUZZER_PRIORITY_EN: only buzzer[1] toggles.
   - Then ack[1] -> active_ch=2, and buzzer[2] is output mid-pattern.
6. Reset asserted while channels are in ALARM and HOLD -> all outputs 0 and alarm_cnt=0 after that edge.
   - Sensor still high after reset release -> alarm re-raised on the 4th edge.
